// File: rtl/rv_mem_responder_if.sv
// Request/response bundle between the core's memory port and the responder.
// Ports: req_valid/req_ready/req_we/req_addr/req_wdata/req_be (request channel),
//        rsp_valid/rsp_ready/rsp_rdata/rsp_err (response channel).
`timescale 1ns/1ps
interface rv_mem_responder_if #(
  parameter int WIDTH     = 32,
  parameter int ADDR_SIZE = 12
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [ADDR_SIZE-1:0]   req_addr;
  logic [WIDTH-1:0]       req_wdata;
  logic [WIDTH/8-1:0]     req_be;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WIDTH-1:0]       rsp_rdata;
  logic                   rsp_err;

  // requester side (core)
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // responder side (memory)
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/rv_mem_responder.sv
// Word-addressed memory answering one valid/ready request at a time.
// Latency: rsp_valid first high LATENCY cycles after the accept edge; next accept one cycle after the rsp handshake.
// Backpressure: response (valid/rdata/err) held until rsp_ready; req_ready low from accept until handshake.
// Ports: clk, rst_n (sync, active-low), bus (rv_mem_responder_if.slave: request + response channels).
// Optional macro RV_MEM_RANGE_CHECK_EN: addr >= MEM_WORDS suppresses the write and returns rsp_err=1.
`timescale 1ns/1ps
module rv_mem_responder #(
  parameter int WIDTH     = 32,
  parameter int ADDR_SIZE = 12,
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input logic              clk,
  input logic              rst_n,
  rv_mem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int BYTES = WIDTH / 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                 state, state_nxt;
  logic [3:0]             cnt, cnt_nxt;
  logic                   accept, commit;

  logic                   cap_we;
  logic [ADDR_SIZE-1:0]   cap_addr;
  logic [WIDTH-1:0]       cap_wdata;
  logic [BYTES-1:0]       cap_be;

  logic                   c_we;
  logic [ADDR_SIZE-1:0]   c_addr;
  logic [WIDTH-1:0]       c_wdata;
  logic [BYTES-1:0]       c_be;
  logic [IDX_W-1:0]       c_idx;
  logic                   oor;
  logic                   mem_we;

  logic [WIDTH-1:0]       rdata_q;
  logic [WIDTH-1:0]       mem [MEM_WORDS];

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_nxt = RESP;
            commit    = 1'b1;
          end else begin
            cnt_nxt   = 4'(LATENCY - 1);
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY=1 the commit happens on the accept edge itself, so the
  // access must use the live bus fields rather than the captured copy.
  assign c_we    = (state == IDLE) ? bus.req_we    : cap_we;
  assign c_addr  = (state == IDLE) ? bus.req_addr  : cap_addr;
  assign c_wdata = (state == IDLE) ? bus.req_wdata : cap_wdata;
  assign c_be    = (state == IDLE) ? bus.req_be    : cap_be;
  assign c_idx   = c_addr[IDX_W-1:0];

`ifdef RV_MEM_RANGE_CHECK_EN
  logic err_q;
  assign oor         = (32'(c_addr) >= 32'(MEM_WORDS));
  assign bus.rsp_err = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (commit) begin
      err_q <= oor;
    end else if (state == RESP && bus.rsp_ready) begin
      err_q <= 1'b0;
    end
  end
`else
  logic unused_addr_hi;
  assign oor            = 1'b0;
  assign bus.rsp_err    = 1'b0;
  assign unused_addr_hi = ^c_addr;
`endif

  // A reset landing on the commit edge must not let a pending write through.
  assign mem_we = commit & c_we & ~oor & rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (commit) begin
        rdata_q <= (c_we || oor) ? '0 : mem[c_idx];
      end else if (state == RESP && bus.rsp_ready) begin
        rdata_q <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_we    <= bus.req_we;
      cap_addr  <= bus.req_addr;
      cap_wdata <= bus.req_wdata;
      cap_be    <= bus.req_be;
    end
  end

  // Storage has no reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTES; i++) begin
      if (mem_we && c_be[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
    end
  end

endmodule
